// File: rtl/gt_link_sequencer.sv
`timescale 1ns/1ps
// gt_link_sequencer: GTP RX lane bring-up, alignment qualification
// and bounded-retry supervision for one receive lane.
module gt_link_sequencer #(
   parameter int unsigned g_GT_RESET_CYCLES = 16,
   parameter int unsigned g_ALIGN_TIMEOUT   = 4096,
   parameter int unsigned g_BLIND_PERIOD    = 10,
   parameter int unsigned g_STABLE_CYCLES   = 1000,
   parameter int unsigned g_MAX_RETRIES     = 7
) (
   input  logic       usrclk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       gt_reset_done_i,
   input  logic       rx_aligned_i,
   input  logic [2:0] rx_bufstatus_i,
   output logic       gt_rx_reset_o,
   output logic       rx_realign_o,
   output logic       valid_o,
   output logic       link_up_o,
   output logic       failed_o,
   output logic [2:0] state_o,
   output logic [7:0] retry_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GT_RST = 3'd1,
      S_WAIT   = 3'd2,
      S_ALIGN  = 3'd3,
      S_BLIND  = 3'd4,
      S_CHECK  = 3'd5,
      S_UP     = 3'd6,
      S_FAIL   = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  retry_q, retry_d;
   logic        fault;
   logic        rx_ok;
   logic        tmo;
   logic        unused_buf;

   assign unused_buf = ^rx_bufstatus_i[1:0];
   assign rx_ok = rx_aligned_i && !rx_bufstatus_i[2];
   assign tmo   = (cnt_q == 32'(g_ALIGN_TIMEOUT - 1));

   always_ff @(posedge usrclk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      fault   = 1'b0;
      // Dropping enable aborts from anywhere and outranks faults.
      if (state_q != S_IDLE && !enable_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (enable_i) begin
                  retry_d = '0;
                  state_d = S_GT_RST;
               end
            end
            S_GT_RST: begin
               if (cnt_q == 32'(g_GT_RESET_CYCLES - 1))
                  state_d = S_WAIT;
            end
            S_WAIT: begin
               if (gt_reset_done_i) state_d = S_ALIGN;
               else if (tmo)        fault   = 1'b1;
            end
            S_ALIGN: begin
               if (rx_aligned_i) state_d = S_BLIND;
               else if (tmo)     fault   = 1'b1;
            end
            S_BLIND: begin
               if (!rx_aligned_i)
                  fault = 1'b1;
               else if (cnt_q == 32'(g_BLIND_PERIOD - 1))
                  state_d = S_CHECK;
            end
            S_CHECK: begin
               if (!rx_ok)
                  fault = 1'b1;
               else if (cnt_q == 32'(g_STABLE_CYCLES - 1))
                  state_d = S_UP;
            end
            S_UP: begin
               if (!rx_ok) fault = 1'b1;
            end
            S_FAIL: begin
               state_d = S_FAIL;
            end
         endcase
         if (fault) begin
            if (retry_q == 8'(g_MAX_RETRIES)) begin
               state_d = S_FAIL;
            end else begin
               retry_d = retry_q + 8'd1;
               state_d = S_GT_RST;
            end
         end
      end
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
   end

   assign gt_rx_reset_o = (state_q == S_GT_RST);
   assign rx_realign_o  = (state_q == S_ALIGN);
   assign valid_o       = (state_q == S_CHECK) || (state_q == S_UP);
   assign link_up_o     = (state_q == S_UP);
   assign failed_o      = (state_q == S_FAIL);
   assign state_o       = state_q;
   assign retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_gt_link_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for gt_link_sequencer: expected state/retry/output
// tuples are queued with the stimulus and popped after each edge.
module tb_gt_link_sequencer;

   localparam logic [2:0] IDLE = 3'd0, GTR = 3'd1, WDN = 3'd2;
   localparam logic [2:0] ALN = 3'd3, BLD = 3'd4, CHK = 3'd5;
   localparam logic [2:0] UPS = 3'd6, FLS = 3'd7;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [7:0] rc;
      logic [4:0] outs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, done, alig;
   logic [2:0] bufs;
   logic       gt_rst, realign, valid, link_up, failed;
   logic [2:0] state;
   logic [7:0] retry;
   logic [4:0] obs;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   gt_link_sequencer #(
      .g_GT_RESET_CYCLES(4),
      .g_ALIGN_TIMEOUT  (50),
      .g_BLIND_PERIOD   (10),
      .g_STABLE_CYCLES  (100),
      .g_MAX_RETRIES    (2)
   ) dut (
      .usrclk_i       (clk),
      .rst_i          (rst),
      .enable_i       (en),
      .gt_reset_done_i(done),
      .rx_aligned_i   (alig),
      .rx_bufstatus_i (bufs),
      .gt_rx_reset_o  (gt_rst),
      .rx_realign_o   (realign),
      .valid_o        (valid),
      .link_up_o      (link_up),
      .failed_o       (failed),
      .state_o        (state),
      .retry_cnt_o    (retry)
   );

   assign obs = {gt_rst, realign, valid, link_up, failed};

   function automatic exp_t mk(input string tag, input logic [2:0] st,
                               input logic [7:0] rc);
      exp_t e;
      e.tag  = tag;
      e.st   = st;
      e.rc   = rc;
      e.outs = {st == GTR, st == ALN, (st == CHK) || (st == UPS),
                st == UPS, st == FLS};
      return e;
   endfunction

   // Nominal trace, i = cycles since leaving IDLE (1 = first GT_RST).
   function automatic logic [2:0] nom_st(input int i);
      if (i <= 4)   return GTR;
      if (i == 5)   return WDN;
      if (i == 6)   return ALN;
      if (i <= 16)  return BLD;
      if (i <= 116) return CHK;
      return UPS;
   endfunction

   // Align never achieved: 55-cycle attempts (4 rst + 1 wait + 50 align).
   function automatic logic [2:0] to_st(input int i);
      int o;
      if (i >= 166) return FLS;
      o = (i - 1) % 55;
      if (o < 4)  return GTR;
      if (o == 4) return WDN;
      return ALN;
   endfunction

   function automatic logic [7:0] to_rc(input int i);
      if (i >= 166) return 8'd2;
      return 8'((i - 1) / 55);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; en = 1'b0; done = 1'b0; alig = 1'b0; bufs = 3'b000;
      tick();
      tick();
      sb.push_back(mk("reset", IDLE, 8'd0));
      e = sb.pop_front();
      total++;
      if ({state, retry, obs} !== {e.st, e.rc, e.outs})
         $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                  e.tag, state, retry, obs, e.st, e.rc, e.outs);
      else passed++;
      rst = 1'b0;
      sb.push_back(mk("idle_hold", IDLE, 8'd0));
      tick();
      e = sb.pop_front();
      total++;
      if ({state, retry, obs} !== {e.st, e.rc, e.outs})
         $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                  e.tag, state, retry, obs, e.st, e.rc, e.outs);
      else passed++;
   endtask

   task automatic test_nominal();
      exp_t e;
      done = 1'b1; alig = 1'b1; bufs = 3'b000;
      for (int i = 1; i <= 120; i++)
         sb.push_back(mk($sformatf("nom%0d", i), nom_st(i), 8'd0));
      en = 1'b1;
      for (int i = 1; i <= 120; i++) begin
         tick();
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
      end
   endtask

   task automatic test_buf_up();
      exp_t e;
      bufs = 3'b110;
      sb.push_back(mk("buf_up", GTR, 8'd1));
      tick();
      bufs = 3'b000;
      e = sb.pop_front();
      total++;
      if ({state, retry, obs} !== {e.st, e.rc, e.outs})
         $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                  e.tag, state, retry, obs, e.st, e.rc, e.outs);
      else passed++;
   endtask

   task automatic test_buf_blind();
      exp_t e;
      for (int i = 2; i <= 17; i++) begin
         sb.push_back(mk($sformatf("blind%0d", i), nom_st(i), 8'd1));
         tick();
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
         if (i == 7)  bufs = 3'b110;
         if (i == 16) bufs = 3'b000;
      end
   endtask

   task automatic test_abort();
      exp_t e;
      en = 1'b0; alig = 1'b0;
      sb.push_back(mk("abort", IDLE, 8'd1));
      sb.push_back(mk("abort_hold", IDLE, 8'd1));
      for (int k = 0; k < 2; k++) begin
         tick();
         alig = 1'b1;
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
      end
   endtask

   task automatic test_align_timeout();
      exp_t e;
      done = 1'b1; alig = 1'b0;
      for (int i = 1; i <= 168; i++)
         sb.push_back(mk($sformatf("tmo%0d", i), to_st(i), to_rc(i)));
      sb.push_back(mk("fail_release", IDLE, 8'd2));
      en = 1'b1;
      for (int i = 1; i <= 169; i++) begin
         if (i == 169) en = 1'b0;
         tick();
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
      end
   endtask

   task automatic test_boundary();
      exp_t e;
      done = 1'b1; alig = 1'b0;
      en = 1'b1;
      for (int i = 1; i <= 56; i++) begin
         if (i <= 55) sb.push_back(mk($sformatf("bnd%0d", i), to_st(i), 8'd0));
         else         sb.push_back(mk("bnd_blind", BLD, 8'd0));
         tick();
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
         if (i == 55) alig = 1'b1;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   n = 0;
      while (state !== UPS && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (state !== UPS)
         $display("FAIL reach_up: got st=%0d want st=%0d within 200 cycles",
                  state, UPS);
      else passed++;
      rst = 1'b1;
      sb.push_back(mk("rst_mid", IDLE, 8'd0));
      sb.push_back(mk("rst_reenter", GTR, 8'd0));
      for (int k = 0; k < 2; k++) begin
         tick();
         rst = 1'b0;
         e = sb.pop_front();
         total++;
         if ({state, retry, obs} !== {e.st, e.rc, e.outs})
            $display("FAIL %s: got st=%0d rc=%0d out=%b want st=%0d rc=%0d out=%b",
                     e.tag, state, retry, obs, e.st, e.rc, e.outs);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_buf_up();
      test_buf_blind();
      test_abort();
      test_align_timeout();
      test_boundary();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gt_link_sequencer.md
# gt_link_sequencer

Bring-up and supervision controller for one GTP receive lane in the OCC PHY testbench. Resets the GT RX, waits for reset completion, requests comma realignment, holds a blind period, then qualifies the link over a stability window before releasing payload traffic to the latency checker. Any loss of alignment or RX elastic-buffer error triggers a bounded retry sequence. The block sits between the GT wrapper and the traffic generator/checker and drives their `valid` and realign controls.

## Interface
Parameters:
- `g_GT_RESET_CYCLES`, 16: cycles `gt_rx_reset_o` is held high per attempt (≥1).
- `g_ALIGN_TIMEOUT`, 4096: max cycles in WAIT_DONE or ALIGN before a fault (≥1).
- `g_BLIND_PERIOD`, 10: cycles after alignment during which only `rx_aligned_i` is checked (≥1).
- `g_STABLE_CYCLES`, 1000: consecutive fault-free cycles required before link up (≥1).
- `g_MAX_RETRIES`, 7: retries allowed before FAIL (0..255).

Ports:
- `usrclk_i` in 1: GT user clock; the only clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `enable_i` in 1: run request; low forces IDLE.
- `gt_reset_done_i` in 1: GT RX reset complete.
- `rx_aligned_i` in 1: GT comma alignment achieved.
- `rx_bufstatus_i` in 3: GT RXBUFSTATUS; bit 2 set = underflow/overflow.
- `gt_rx_reset_o` out 1: GT RX reset request.
- `rx_realign_o` out 1: comma realign enable.
- `valid_o` out 1: payload allowed; low = traffic generator sends IDLE only.
- `link_up_o` out 1: link qualified.
- `failed_o` out 1: retries exhausted; sticky until `enable_i` low.
- `state_o` out 3: current state encoding.
- `retry_cnt_o` out 8: retries performed in the current run.

## Operation
- States and encodings: IDLE=0, GT_RST=1, WAIT_DONE=2, ALIGN=3, BLIND=4, CHECK=5, UP=6, FAIL=7.
- One cycle counter `cnt` (32 bits) is cleared on every state change and increments each cycle otherwise.
- IDLE: if `enable_i`, clear `retry_cnt_o` and go to GT_RST.
- GT_RST: go to WAIT_DONE when `cnt == g_GT_RESET_CYCLES-1`.
- WAIT_DONE: go to ALIGN on `gt_reset_done_i`. Fault when `cnt == g_ALIGN_TIMEOUT-1` without it.
- ALIGN: go to BLIND on `rx_aligned_i`. Fault on timeout, using the same rule as WAIT_DONE.
- BLIND: fault if `rx_aligned_i` is low. `rx_bufstatus_i` is ignored here. Go to CHECK when `cnt == g_BLIND_PERIOD-1` with `rx_aligned_i` high.
- CHECK: fault if `rx_aligned_i` is low or `rx_bufstatus_i[2]` is set. Go to UP when `cnt == g_STABLE_CYCLES-1` with no fault.
- UP: same fault rule as CHECK. Otherwise stay.
- Fault handling: if `retry_cnt_o == g_MAX_RETRIES`, go to FAIL with the count unchanged. Otherwise increment `retry_cnt_o` and go to GT_RST.
- FAIL: stay until `enable_i` is low.
- Output decode (Moore, from the state register):
  - `gt_rx_reset_o` = GT_RST.
  - `rx_realign_o` = ALIGN.
  - `valid_o` = CHECK or UP.
  - `link_up_o` = UP.
  - `failed_o` = FAIL.

## Timing
- Reset: state IDLE, `cnt` 0, `retry_cnt_o` 0, all 1-bit outputs 0, `state_o` 0.
- All transitions occur on the `usrclk_i` edge. Outputs change in the same cycle that `state_o` shows the new state.
- `enable_i` sampled high in IDLE at edge k: GT_RST is visible after edge k, and `gt_rx_reset_o` is high for exactly `g_GT_RESET_CYCLES` cycles.
- Success condition and timeout in the same cycle: success wins.
- `enable_i` low in any non-IDLE state: next state is IDLE. This has priority over faults and success, and a coincident fault does not increment the retry count.
- `rst_i` mid-operation: immediate return to reset values; no retry is counted.
- Minimum enable-to-link-up latency, counted in cycles in which `state_o` is non-IDLE: `g_GT_RESET_CYCLES + 1 + 1 + g_BLIND_PERIOD + g_STABLE_CYCLES`. This holds when done and aligned are already high on entry.
- A fault in UP drops `link_up_o` and `valid_o` one cycle after the faulting sample.

## Test plan
Parameters for all scenarios: `g_GT_RESET_CYCLES`=4, `g_ALIGN_TIMEOUT`=50, `g_BLIND_PERIOD`=10, `g_STABLE_CYCLES`=100, `g_MAX_RETRIES`=2.
- **Nominal bring-up:** `enable_i`=1, with done and aligned high; bufstatus=000. Expect `gt_rx_reset_o` high 4 cycles, then `link_up_o`=1 exactly 116 cycles after leaving IDLE, `valid_o`=1 from CHECK entry, `retry_cnt_o`=0.
- **Align timeout exhaustion:** `rx_aligned_i` held 0. Expect 3 ALIGN periods of 50 cycles each, `retry_cnt_o` 0→1→2, then `failed_o`=1 with `state_o`=7. Dropping `enable_i` returns to IDLE with `failed_o`=0.
- **Buffer error:** in UP, `rx_bufstatus_i`=110 for 1 cycle. Expect `link_up_o`=0 next cycle, `state_o`=1, `retry_cnt_o`=1. The same value applied during BLIND must be ignored.
- **Boundary:** `rx_aligned_i` rises on cycle 49 of ALIGN, coinciding with the timeout. Expect BLIND, not a retry.
- **Abort priority:** `enable_i` low in the same cycle as an alignment loss in CHECK. Expect IDLE next cycle with `retry_cnt_o` unchanged.
- **Reset mid-run:** `rst_i` pulsed in UP. Expect all outputs at reset values the next cycle. With `enable_i` still high, GT_RST is re-entered the cycle after `rst_i` falls.
